// File: rtl/line_window_kxk_if.sv
// rtl/line_window_kxk_if.sv - pixel stream in / flattened KxK window out bundle
// WIN_COORD_EN adds the win_x/win_y centre coordinate signals.
interface line_window_kxk_if #(
  parameter int DW = 8,
  parameter int K  = 3
`ifdef WIN_COORD_EN
  ,
  parameter int XW = 11,
  parameter int YW = 11
`endif
);
  logic               din_valid;
  logic [DW-1:0]      din;
  logic               sof;
  logic [K*K*DW-1:0]  win;
  logic               win_valid;
  logic               frame_done;
  logic               sync_err;
`ifdef WIN_COORD_EN
  logic [XW-1:0]      win_x;
  logic [YW-1:0]      win_y;
`endif

  modport master (
    output din_valid, din, sof,
    input  win, win_valid, frame_done, sync_err
`ifdef WIN_COORD_EN
    ,
    input  win_x, win_y
`endif
  );

  modport slave (
    input  din_valid, din, sof,
    output win, win_valid, frame_done, sync_err
`ifdef WIN_COORD_EN
    ,
    output win_x, win_y
`endif
  );
endinterface

// File: rtl/line_window_kxk.sv
// rtl/line_window_kxk.sv - KxK sliding-window generator over K-1 line stores
// Optional WIN_COORD_EN macro adds registered window-centre coordinates.
module line_window_kxk #(
  parameter int DW    = 8,
  parameter int K     = 3,
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int XW    = 11,
  parameter int YW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  line_window_kxk_if.slave bus
);
  localparam int             AW      = $clog2(IMG_W);
  localparam logic [XW-1:0]  X_LAST  = XW'(IMG_W - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(IMG_H - 1);
  localparam logic [XW-1:0]  X_FIRST = XW'(K - 1);
  localparam logic [YW-1:0]  Y_FIRST = YW'(K - 1);

  logic [XW-1:0]     r_x;
  logic [YW-1:0]     r_y;
  logic [DW-1:0]     r_lb  [K-1][IMG_W];
  logic [DW-1:0]     r_win [K][K];
  logic              r_win_valid;
  logic              r_frame_done;
  logic              r_sync_err;

  logic              w_accept;
  logic [XW-1:0]     w_x;
  logic [YW-1:0]     w_y;
  logic [AW-1:0]     w_addr;
  logic              w_win_ok;
  logic [DW-1:0]     w_col [K];
  logic [K*K*DW-1:0] w_win;

  // sof forces the current pixel to (0,0) whatever the counters say
  assign w_accept = bus.din_valid;
  assign w_x      = bus.sof ? '0 : r_x;
  assign w_y      = bus.sof ? '0 : r_y;
  assign w_addr   = w_x[AW-1:0];
  assign w_win_ok = (w_x >= X_FIRST) && (w_y >= Y_FIRST);

  always_comb begin
    for (int r = 0; r < K-1; r++) begin
      w_col[r] = r_lb[K-2-r][w_addr];
    end
    w_col[K-1] = bus.din;
  end

  // Store i passes its old pixel down to store i+1 as it takes the newer one
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb[0][w_addr] <= bus.din;
      for (int i = 1; i < K-1; i++) begin
        r_lb[i][w_addr] <= r_lb[i-1][w_addr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x          <= '0;
      r_y          <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_sync_err   <= 1'b0;
      if (w_accept) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K-1; c++) begin
            r_win[r][c] <= r_win[r][c+1];
          end
          r_win[r][K-1] <= w_col[r];
        end
        r_win_valid  <= w_win_ok;
        r_frame_done <= (w_x == X_LAST) && (w_y == Y_LAST);
        r_sync_err   <= bus.sof && ((r_x != '0) || (r_y != '0));
        if (w_x == X_LAST) begin
          r_x <= '0;
          r_y <= (w_y == Y_LAST) ? '0 : w_y + YW'(1);
        end else begin
          r_x <= w_x + XW'(1);
          r_y <= w_y;
        end
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    for (genvar c = 0; c < K; c++) begin : g_col
      assign w_win[(r*K+c)*DW +: DW] = r_win[r][c];
    end
  end

  assign bus.win        = w_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.frame_done = r_frame_done;
  assign bus.sync_err   = r_sync_err;

`ifdef WIN_COORD_EN
  localparam logic [XW-1:0] X_HALF = XW'((K - 1) / 2);
  localparam logic [YW-1:0] Y_HALF = YW'((K - 1) / 2);

  logic [XW-1:0] r_win_x;
  logic [YW-1:0] r_win_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_x <= '0;
      r_win_y <= '0;
    end else if (w_accept && w_win_ok) begin
      r_win_x <= w_x - X_HALF;
      r_win_y <= w_y - Y_HALF;
    end
  end

  assign bus.win_x = r_win_x;
  assign bus.win_y = r_win_y;
`endif
endmodule

// File: tb/tb_line_window_kxk.sv
// tb/tb_line_window_kxk.sv - directed bench for line_window_kxk (K=3 8x6 and K=5 16x8)
// Build with WIN_COORD_EN defined to also cover win_x/win_y.
module tb_line_window_kxk;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  localparam logic [71:0] FIRST3 = 72'h22_21_20_12_11_10_02_01_00;

  always #5 clk = ~clk;

`ifdef WIN_COORD_EN
  line_window_kxk_if #(.DW(8), .K(3), .XW(4), .YW(4)) bus3 ();
  line_window_kxk_if #(.DW(8), .K(5), .XW(5), .YW(4)) bus5 ();
`else
  line_window_kxk_if #(.DW(8), .K(3)) bus3 ();
  line_window_kxk_if #(.DW(8), .K(5)) bus5 ();
`endif

  line_window_kxk #(.DW(8), .K(3), .IMG_W(8), .IMG_H(6), .XW(4), .YW(4)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );
  line_window_kxk #(.DW(8), .K(5), .IMG_W(16), .IMG_H(8), .XW(5), .YW(4)) u_dut5 (
    .clk(clk), .rst(rst), .bus(bus5)
  );

  // Reference window from pixel value y*16+x+off, bottom-right at (bx,by)
  function automatic logic [199:0] model_win(int k, int bx, int by, int off);
    logic [199:0] v;
    v = '0;
    for (int r = 0; r < k; r++)
      for (int c = 0; c < k; c++)
        v[(r*k+c)*8 +: 8] = 8'((by-(k-1)+r)*16 + (bx-(k-1)+c) + off);
    return v;
  endfunction

  task automatic push3(input logic v, input logic [7:0] d, input logic s);
    bus3.din_valid = v; bus3.din = d; bus3.sof = s;
    @(posedge clk); #1;
  endtask

  task automatic push5(input logic v, input logic [7:0] d, input logic s);
    bus5.din_valid = v; bus5.din = d; bus5.sof = s;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus3.din_valid = 1'b0; bus3.din = '0; bus3.sof = 1'b0;
    bus5.din_valid = 1'b0; bus5.din = '0; bus5.sof = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus3.win !== '0) begin n_fail++; $display("FAIL reset_win3 got %h want 0", bus3.win); end
    n_cmp++; if ({bus3.win_valid, bus3.frame_done, bus3.sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags3 got %b want 000", {bus3.win_valid, bus3.frame_done, bus3.sync_err}); end
    n_cmp++; if (bus5.win !== '0) begin n_fail++; $display("FAIL reset_win5 got %h want 0", bus5.win); end
    n_cmp++; if ({bus5.win_valid, bus5.frame_done, bus5.sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags5 got %b want 000", {bus5.win_valid, bus5.frame_done, bus5.sync_err}); end
`ifdef WIN_COORD_EN
    n_cmp++; if (bus3.win_x !== 4'd0 || bus3.win_y !== 4'd0) begin
      n_fail++; $display("FAIL reset_coord got %0d,%0d want 0,0", bus3.win_x, bus3.win_y); end
`endif
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_frame;
    int nwin = 0, nfd = 0;
    logic ev;
    logic [199:0] m;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        push3(1'b1, 8'(y*16+x), (x == 0 && y == 0));
        ev = (x >= 2 && y >= 2);
        m  = model_win(3, x, y, 0);
        n_cmp++; if (bus3.win_valid !== ev) begin
          n_fail++; $display("FAIL full_valid (%0d,%0d) got %b want %b", x, y, bus3.win_valid, ev); end
        if (ev) begin
          n_cmp++; if (bus3.win !== m[71:0]) begin
            n_fail++; $display("FAIL full_win (%0d,%0d) got %h want %h", x, y, bus3.win, m[71:0]); end
`ifdef WIN_COORD_EN
          n_cmp++; if (bus3.win_x !== 4'(x-1) || bus3.win_y !== 4'(y-1)) begin
            n_fail++; $display("FAIL full_coord (%0d,%0d) got %0d,%0d", x, y, bus3.win_x, bus3.win_y); end
`endif
        end
        if (x == 2 && y == 2) begin
          n_cmp++; if (bus3.win !== FIRST3) begin
            n_fail++; $display("FAIL first_win got %h want %h", bus3.win, FIRST3); end
        end
        if (bus3.win_valid === 1'b1 && bus3.win[3:0] === 4'h7) begin
          n_cmp++; n_fail++; $display("FAIL wrap_window at (%0d,%0d) got c0=%h", x, y, bus3.win[7:0]);
        end
        n_cmp++; if (bus3.frame_done !== (x == 7 && y == 5)) begin
          n_fail++; $display("FAIL full_frame_done (%0d,%0d) got %b", x, y, bus3.frame_done); end
        n_cmp++; if (bus3.sync_err !== 1'b0) begin
          n_fail++; $display("FAIL full_sync_err (%0d,%0d) got %b want 0", x, y, bus3.sync_err); end
        if (bus3.win_valid === 1'b1) nwin++;
        if (bus3.frame_done === 1'b1) nfd++;
      end
    end
    n_cmp++; if (nwin !== 24) begin n_fail++; $display("FAIL full_count got %0d want 24", nwin); end
    n_cmp++; if (nfd !== 1) begin n_fail++; $display("FAIL full_fd_count got %0d want 1", nfd); end
    push3(1'b0, 8'h00, 1'b0);
    n_cmp++; if ({bus3.win_valid, bus3.frame_done} !== 2'b00) begin
      n_fail++; $display("FAIL full_idle got %b want 00", {bus3.win_valid, bus3.frame_done}); end
  endtask

  task automatic test_gaps;
    int nwin = 0, ng;
    logic ev;
    logic [199:0] m;
    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 8; x++) begin
        ng = 0;
        while ($urandom_range(0, 99) < 40 && ng < 5) begin
          ng++;
          push3(1'b0, 8'hEE, 1'b1);
          n_cmp++; if ({bus3.win_valid, bus3.frame_done, bus3.sync_err} !== 3'b000) begin
            n_fail++; $display("FAIL gap_outputs (%0d,%0d) got %b want 000", x, y,
                               {bus3.win_valid, bus3.frame_done, bus3.sync_err}); end
        end
        push3(1'b1, 8'(y*16+x), (x == 0 && y == 0));
        ev = (x >= 2 && y >= 2);
        m  = model_win(3, x, y, 0);
        n_cmp++; if (bus3.win_valid !== ev) begin
          n_fail++; $display("FAIL gap_valid (%0d,%0d) got %b want %b", x, y, bus3.win_valid, ev); end
        if (ev) begin
          n_cmp++; if (bus3.win !== m[71:0]) begin
            n_fail++; $display("FAIL gap_win (%0d,%0d) got %h want %h", x, y, bus3.win, m[71:0]); end
        end
        n_cmp++; if (bus3.frame_done !== (x == 7 && y == 5)) begin
          n_fail++; $display("FAIL gap_frame_done (%0d,%0d) got %b", x, y, bus3.frame_done); end
        n_cmp++; if (bus3.sync_err !== 1'b0) begin
          n_fail++; $display("FAIL gap_sync_err (%0d,%0d) got %b want 0", x, y, bus3.sync_err); end
        if (bus3.win_valid === 1'b1) nwin++;
      end
    end
    n_cmp++; if (nwin !== 24) begin n_fail++; $display("FAIL gap_count got %0d want 24", nwin); end
  endtask

  task automatic test_resync;
    int nwin = 0, nerr = 0, first = -1;
    int x, y;
    logic ev;
    logic [199:0] m;
    for (int i = 0; i < 20; i++) begin
      x = i % 8; y = i / 8;
      push3(1'b1, 8'(y*16+x), (i == 0));
      ev = (x >= 2 && y >= 2);
      n_cmp++; if (bus3.win_valid !== ev) begin
        n_fail++; $display("FAIL pre_valid idx %0d got %b want %b", i, bus3.win_valid, ev); end
      if (bus3.sync_err === 1'b1) nerr++;
    end
    for (int i = 0; i < 48; i++) begin
      x = i % 8; y = i / 8;
      push3(1'b1, 8'(y*16+x+8'h80), (i == 0));
      ev = (x >= 2 && y >= 2);
      m  = model_win(3, x, y, 8'h80);
      n_cmp++; if (bus3.sync_err !== (i == 0)) begin
        n_fail++; $display("FAIL resync_err idx %0d got %b want %b", i, bus3.sync_err, (i == 0)); end
      n_cmp++; if (bus3.win_valid !== ev) begin
        n_fail++; $display("FAIL resync_valid idx %0d got %b want %b", i, bus3.win_valid, ev); end
      if (ev) begin
        n_cmp++; if (bus3.win !== m[71:0]) begin
          n_fail++; $display("FAIL resync_win idx %0d got %h want %h", i, bus3.win, m[71:0]); end
      end
      if (bus3.win_valid === 1'b1) begin
        nwin++;
        if (first < 0) first = i;
      end
      if (bus3.sync_err === 1'b1) nerr++;
    end
    n_cmp++; if (nerr !== 1) begin n_fail++; $display("FAIL resync_err_count got %0d want 1", nerr); end
    n_cmp++; if (first !== 18) begin n_fail++; $display("FAIL resync_first got %0d want 18", first); end
    n_cmp++; if (nwin !== 24) begin n_fail++; $display("FAIL resync_count got %0d want 24", nwin); end
  endtask

  task automatic test_reset_midframe;
    int nwin = 0;
    int x, y;
    logic ev;
    logic [199:0] m;
    for (int i = 0; i < 30; i++) begin
      x = i % 8; y = i / 8;
      push3(1'b1, 8'(y*16+x+8'h40), (i == 0));
    end
    n_cmp++; if (bus3.win_valid !== 1'b1) begin
      n_fail++; $display("FAIL midrst_pre_valid got %b want 1", bus3.win_valid); end
    rst = 1'b0;
    #1;
    n_cmp++; if (bus3.win !== '0 || {bus3.win_valid, bus3.frame_done, bus3.sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_clear got %h/%b want 0", bus3.win,
                         {bus3.win_valid, bus3.frame_done, bus3.sync_err}); end
    #3;
    push3(1'b1, 8'h55, 1'b1);
    push3(1'b1, 8'h55, 1'b0);
    n_cmp++; if (bus3.win !== '0 || {bus3.win_valid, bus3.frame_done, bus3.sync_err} !== 3'b000) begin
      n_fail++; $display("FAIL midrst_hold got %h/%b want 0", bus3.win,
                         {bus3.win_valid, bus3.frame_done, bus3.sync_err}); end
`ifdef WIN_COORD_EN
    n_cmp++; if (bus3.win_x !== 4'd0 || bus3.win_y !== 4'd0) begin
      n_fail++; $display("FAIL midrst_coord got %0d,%0d want 0,0", bus3.win_x, bus3.win_y); end
`endif
    bus3.din_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 48; i++) begin
      x = i % 8; y = i / 8;
      push3(1'b1, 8'(y*16+x), 1'b0);
      ev = (x >= 2 && y >= 2);
      m  = model_win(3, x, y, 0);
      n_cmp++; if (bus3.win_valid !== ev) begin
        n_fail++; $display("FAIL postrst_valid idx %0d got %b want %b", i, bus3.win_valid, ev); end
      if (ev) begin
        n_cmp++; if (bus3.win !== m[71:0]) begin
          n_fail++; $display("FAIL postrst_win idx %0d got %h want %h", i, bus3.win, m[71:0]); end
      end
      if (i == 18) begin
        n_cmp++; if (bus3.win !== FIRST3) begin
          n_fail++; $display("FAIL postrst_first got %h want %h", bus3.win, FIRST3); end
      end
      if (bus3.win_valid === 1'b1) nwin++;
    end
    n_cmp++; if (nwin !== 24) begin n_fail++; $display("FAIL postrst_count got %0d want 24", nwin); end
  endtask

  task automatic test_k5;
    int nwin = 0, nfd = 0;
    logic ev;
    logic [7:0] exp_px;
    logic [199:0] m;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 16; x++) begin
        push5(1'b1, 8'(y*16+x), (x == 0 && y == 0));
        ev = (x >= 4 && y >= 4);
        m  = model_win(5, x, y, 0);
        n_cmp++; if (bus5.win_valid !== ev) begin
          n_fail++; $display("FAIL k5_valid (%0d,%0d) got %b want %b", x, y, bus5.win_valid, ev); end
        if (ev) begin
          n_cmp++; if (bus5.win !== m) begin
            n_fail++; $display("FAIL k5_win (%0d,%0d) got %h want %h", x, y, bus5.win, m); end
        end
        if (x == 4 && y == 4) begin
          for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
              exp_px = 8'(r*16 + c);
              n_cmp++; if (bus5.win[(r*5+c)*8 +: 8] !== exp_px) begin
                n_fail++; $display("FAIL k5_slice r%0d c%0d got %h want %h", r, c,
                                   bus5.win[(r*5+c)*8 +: 8], exp_px); end
            end
          end
          n_cmp++; if (bus5.win[(2*5+2)*8 +: 8] !== 8'h22 || bus5.win[(4*5+4)*8 +: 8] !== 8'h44) begin
            n_fail++; $display("FAIL k5_centre got %h/%h want 22/44",
                               bus5.win[(2*5+2)*8 +: 8], bus5.win[(4*5+4)*8 +: 8]); end
`ifdef WIN_COORD_EN
          n_cmp++; if (bus5.win_x !== 5'd2 || bus5.win_y !== 4'd2) begin
            n_fail++; $display("FAIL k5_coord got %0d,%0d want 2,2", bus5.win_x, bus5.win_y); end
`endif
        end
        if (bus5.win_valid === 1'b1) nwin++;
        if (bus5.frame_done === 1'b1) nfd++;
      end
    end
    n_cmp++; if (nwin !== 48) begin n_fail++; $display("FAIL k5_count got %0d want 48", nwin); end
    n_cmp++; if (nfd !== 1) begin n_fail++; $display("FAIL k5_fd_count got %0d want 1", nfd); end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_gaps();
    test_resync();
    test_reset_midframe();
    test_k5();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
